pwm_fade_controller: RTL
========================

# pwm_fade_controller

Sequences the duty-cycle inputs of a bank of PWM generator channels, e.g. the R/G/B LED drivers. Software-side logic issues per-channel commands (target duty plus step size). The block ramps each channel's duty from its current value to the target, one step per prescaled tick, and drives the result onto each generator's 32-bit `duty_cycle` input. It sits between the register/command interface and the `pwm_generator` instances, and it owns all duty-cycle updates.

## Interface
- `NUM_CH`, 3: number of PWM channels driven.
- `DUTY_W`, 9: internal duty width; must hold `MAX_DUTY`.
- `MAX_DUTY`, 256: saturation ceiling. 256 drives a channel permanently high with a 255-count generator.
- `TICK_DIV`, 1000: clock cycles per ramp tick; must be ≥ 1.

- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command can be accepted this cycle.
- `cmd_ch` in $clog2(NUM_CH): target channel index.
- `cmd_target` in 32: requested duty; saturated to `MAX_DUTY`.
- `cmd_step` in `DUTY_W`: per-tick increment; 0 means jump immediately.
- `duty_out` out `NUM_CH*32`: channel *i* occupies bits [32*i+31:32*i]. Zero-extended current duty.
- `busy` out 1: at least one channel has current ≠ target.
- `done` out 1: one-cycle pulse when the last ramping channel reaches its target.

## Operation
- Per channel, registered state: `cur`, `tgt`, `step` (all `DUTY_W`).
- Command acceptance:
  - `cmd_ready` is 1 whenever the block is out of reset.
  - A command is accepted when `cmd_valid && cmd_ready` at a clock edge.
  - `cmd_ch >= NUM_CH`: the command is accepted and dropped; no state changes.
  - On accept: `tgt[ch] <= sat(cmd_target)`, `step[ch] <= cmd_step`.
  - If `cmd_step == 0`, also `cur[ch] <= sat(cmd_target)` in the same edge.
- Prescaler:
  - A counter 0..`TICK_DIV-1` runs continuously.
  - `tick` is asserted in the cycle where the counter equals `TICK_DIV-1`.
  - The counter wraps to 0 on that cycle.
- Ramping, on `tick`, for each channel with `cur ≠ tgt`:
  - `cur` moves toward `tgt` by `min(step, |tgt − cur|)`.
  - No overshoot and no wrap-around. The arithmetic is unsigned at `DUTY_W+1` bits.
- Simultaneous command and tick on the same channel: the command wins, and that channel is not stepped on that tick.
- FSM states:
  - IDLE: all `cur == tgt`.
  - RAMP: any channel mismatched.
  - IDLE→RAMP on the edge where any mismatch appears.
  - RAMP→IDLE on the edge where all match again.
  - `done` pulses for exactly one cycle on RAMP→IDLE.
  - A jump command (`step` 0) never enters RAMP and never pulses `done`.
- A retarget during RAMP keeps the FSM in RAMP. The ramp continues from the current `cur`.
- `busy` is 1 exactly in state RAMP.

## Timing
- Reset values (asserted asynchronously, held until release):
  - `cur`, `tgt`, `step` = 0.
  - `duty_out` = 0.
  - `busy` = 0, `done` = 0.
  - Prescaler = 0; FSM = IDLE.
  - `cmd_ready` = 0 while `reset` is low.
- Reset mid-ramp: all channels drop to 0 immediately. No `done` pulse.
- `duty_out` is registered and reflects `cur` with no extra latency. A jump command is visible on `duty_out` in the cycle after acceptance.
- A ramp of distance D with step S completes on tick ceil(D/S) after acceptance. `done` is high in the cycle after that tick's edge.
- The first tick after reset release occurs `TICK_DIV` cycles after release.

## Configuration
- `PWM_FADE_EN` defined:
  - Behaviour is as specified above.
- `PWM_FADE_EN` undefined:
  - The prescaler, `step` registers and FSM are compiled out.
  - Every accepted command behaves as `cmd_step == 0`, i.e. an immediate jump.
  - `busy` is tied to 0; `done` is tied to 0.
  - `cmd_step` is ignored.

## Structure
- Shared package `pwm_pkg`:
  - FSM state enum `fade_state_t` (IDLE, RAMP).
  - `PWM_DUTY_W` default.
  - `PWM_MAX_DUTY` default (256), matching the generator's `MAX_COUNT+1`.
  - Function `sat_duty`.
- Natural sub-module: `pwm_fade_channel`, one instance per channel. It holds `cur`/`tgt`/`step`, handles the update/step logic and outputs `at_target`.
- The top level holds the prescaler, FSM, command decode and `duty_out` packing.

## Test plan
- Reset, release, no commands → `duty_out` = 0, `busy` = 0, `cmd_ready` = 1 from the first cycle after release.
- `TICK_DIV=4`; command ch0, target 100, step 0 → `duty_out[31:0]` = 100 in the next cycle; `busy` never asserts; no `done`.
- `TICK_DIV=4`; ch1 at 0, command target 10, step 3 → ch1 = 3, 6, 9, 10 on successive ticks. `busy` is high throughout; one `done` pulse after the 10.
- Command target 1000, step 0 → saturates to 256. Then target 0, step 100 → 156, 56, 0; no underflow.
- Command on ch2 in the exact cycle of a tick while ch2 is ramping → ch2 is not stepped that tick; the new `tgt`/`step` apply from the next tick. Also `cmd_ch=3` with `NUM_CH=3` → no state change.
- Assert `reset` mid-ramp at ch0 = 40 → `duty_out` = 0 asynchronously; no `done`. After release, `busy` = 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types, defaults and helpers for the PWM fade controller slice.
package pwm_pkg;

  typedef enum logic {
    IDLE,
    RAMP
  } fade_state_t;

  localparam int unsigned PWM_DUTY_W   = 9;
  localparam int unsigned PWM_MAX_DUTY = 256;

  function automatic logic [31:0] sat_duty(input logic [31:0] value,
                                           input logic [31:0] max_duty);
    return (value > max_duty) ? max_duty : value;
  endfunction

endpackage

// File: rtl/pwm_fade_controller_if.sv
// Command handshake between register/command logic and the fade controller.
interface pwm_fade_controller_if
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DUTY_W = PWM_DUTY_W
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CH_W-1:0]   cmd_ch;
  logic [31:0]       cmd_target;
  logic [DUTY_W-1:0] cmd_step;

  modport master (
    output cmd_valid, cmd_ch, cmd_target, cmd_step,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_target, cmd_step,
    output cmd_ready
  );

endinterface

// File: rtl/pwm_fade_channel.sv
// One duty channel: holds cur/tgt/step and applies loads and tick steps.
// With PWM_FADE_EN undefined only cur is kept and every load is a jump.
module pwm_fade_channel
  import pwm_pkg::*;
#(
  parameter int DUTY_W = PWM_DUTY_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DUTY_W-1:0] load_tgt,
`ifdef PWM_FADE_EN
  input  logic [DUTY_W-1:0] load_step,
  input  logic              tick,
  output logic              at_target,
`endif
  output logic [DUTY_W-1:0] cur
);

  logic [DUTY_W-1:0] cur_q, cur_d;

`ifdef PWM_FADE_EN
  logic [DUTY_W-1:0] tgt_q, tgt_d, step_q, step_d;
  logic [DUTY_W:0]   dist, delta;

  always_comb begin
    cur_d  = cur_q;
    tgt_d  = tgt_q;
    step_d = step_q;
    dist   = (tgt_q >= cur_q) ? ({1'b0, tgt_q} - {1'b0, cur_q})
                              : ({1'b0, cur_q} - {1'b0, tgt_q});
    delta  = ({1'b0, step_q} < dist) ? {1'b0, step_q} : dist;
    // A load on this channel takes priority over a coincident tick.
    if (load) begin
      tgt_d  = load_tgt;
      step_d = load_step;
      if (load_step == '0) cur_d = load_tgt;
    end else if (tick && (cur_q != tgt_q)) begin
      if (tgt_q > cur_q) cur_d = DUTY_W'({1'b0, cur_q} + delta);
      else               cur_d = DUTY_W'({1'b0, cur_q} - delta);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_q  <= '0;
      tgt_q  <= '0;
      step_q <= '0;
    end else begin
      cur_q  <= cur_d;
      tgt_q  <= tgt_d;
      step_q <= step_d;
    end
  end

  // Match as it will stand after the coming edge, so the FSM tracks cur/tgt without lag.
  assign at_target = (cur_d == tgt_d);
`else
  always_comb begin
    cur_d = load ? load_tgt : cur_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cur_q <= '0;
    else        cur_q <= cur_d;
  end
`endif

  assign cur = cur_q;

endmodule

// File: rtl/pwm_fade_controller.sv
// Ramps each PWM channel's duty toward its commanded target, one step per tick.
// PWM_FADE_EN enables ramping; without it every command is an immediate jump.
module pwm_fade_controller
  import pwm_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int DUTY_W   = PWM_DUTY_W,
  parameter int MAX_DUTY = PWM_MAX_DUTY,
  parameter int TICK_DIV = 1000
) (
  input  logic                 clock,
  input  logic                 reset,
  pwm_fade_controller_if.slave cmd,
  output logic [NUM_CH*32-1:0] duty_out,
  output logic                 busy,
  output logic                 done
);

  logic              ready_q, ready_d;
  logic [31:0]       ch_ext;
  logic              accept;
  logic [DUTY_W-1:0] sat_tgt;
  logic [NUM_CH-1:0] load;
  logic [DUTY_W-1:0] cur [NUM_CH];

  assign ready_d = 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ready_q <= 1'b0;
    else        ready_q <= ready_d;
  end

  assign cmd.cmd_ready = ready_q;

  // Out-of-range channel indices are accepted but load nothing.
  always_comb begin
    ch_ext  = 32'(cmd.cmd_ch);
    accept  = cmd.cmd_valid && ready_q && (ch_ext < 32'(NUM_CH));
    sat_tgt = DUTY_W'(sat_duty(cmd.cmd_target, 32'(MAX_DUTY)));
    load    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      load[i] = accept && (ch_ext == 32'(i));
    end
  end

`ifdef PWM_FADE_EN
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick;
  logic [NUM_CH-1:0] match;
  fade_state_t       state_q, state_d;
  logic              done_q, done_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = (&match) ? IDLE : RAMP;
    done_d  = (state_q == RAMP) && (state_d == IDLE);
  end

  always_comb begin
    busy = (state_q == RAMP);
    done = done_q;
  end
`else
  // TICK_DIV below 1 is not a supported configuration.
  if (TICK_DIV < 1) begin : g_bad_tick_div
  end

  assign busy = 1'b0;
  assign done = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_fade_channel #(
      .DUTY_W(DUTY_W)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .load     (load[g]),
      .load_tgt (sat_tgt),
`ifdef PWM_FADE_EN
      .load_step(cmd.cmd_step),
      .tick     (tick),
      .at_target(match[g]),
`endif
      .cur      (cur[g])
    );

    assign duty_out[32*g +: 32] = 32'(cur[g]);
  end

endmodule
